// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit owning the HI/LO register pair (EXE stage).
// MULT/MULTU complete in one MUL cycle followed by a WB cycle.
// DIV/DIVU use restoring radix-2 division, one quotient bit per cycle over
// WIDTH cycles, followed by a WB cycle.
// MTHI/MTLO writes are accepted in any state.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle launch pulse, honoured only in IDLE
//   ALU2Op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   RHLWr      HI/LO direct write request
//   RHLSel_Wr  00 MTLO, 01 MTHI, 10 result path (no direct write)
//   flush      cancels any in-flight operation
//   A, B       rs / rt operands
//   HI, LO     architectural HI/LO registers
//   busy       high while not IDLE
//   done       one-cycle pulse in the WB cycle (suppressed by flush)
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ALU2Op,
    input  logic             RHLWr,
    input  logic [1:0]       RHLSel_Wr,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // a_q holds |A|; during division it doubles as the dividend/quotient
    // shifter: dividend bits leave at the top, quotient bits enter at the bottom.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [DW-1:0]    prod_q, prod_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   rem_sh;
    logic             q_bit;
    logic signed [DW-1:0] wb_prod;
    logic [WIDTH-1:0] wb_hi, wb_lo;
    logic             sign_a, sign_b;

    // Magnitude of a value that is negative when neg is set. The most
    // negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        logic signed [WIDTH-1:0] sx;
        sx = signed'(x);
        return neg ? unsigned'(-sx) : x;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        prod_d  = prod_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        sign_a = ALU2Op[0] & A[WIDTH-1];
        sign_b = ALU2Op[0] & B[WIDTH-1];

        // One restoring-division step. A zero divisor always "fits", which
        // yields an all-ones quotient and leaves |A| as the remainder.
        rem_sh = {rem_q, a_q[WIDTH-1]};
        q_bit  = (rem_sh >= {1'b0, b_q});

        wb_prod = negq_q ? -signed'(prod_q) : signed'(prod_q);
        if (div_q) begin
            wb_hi = cond_neg(rem_q, negr_q);
            wb_lo = cond_neg(a_q, negq_q);
        end else begin
            wb_hi = wb_prod[DW-1:WIDTH];
            wb_lo = wb_prod[WIDTH-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    a_d     = cond_neg(A, sign_a);
                    b_d     = cond_neg(B, sign_b);
                    negq_d  = sign_a ^ sign_b;
                    negr_d  = sign_a;
                    div_d   = ALU2Op[1];
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = ALU2Op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                prod_d  = DW'(a_q) * DW'(b_q);
                state_d = S_WB;
            end
            S_DIV: begin
                rem_d = q_bit ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (!flush) begin
                    hi_d = wb_hi;
                    lo_d = wb_lo;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end

        // Direct writes take priority over the WB result for their target.
        if (RHLWr && RHLSel_Wr == 2'b01) begin
            hi_d = A;
        end
        if (RHLWr && RHLSel_Wr == 2'b00) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            prod_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            prod_q  <= prod_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_WB) && !flush;

endmodule
